// File: rtl/drum_pkg.sv
// rtl/drum_pkg.sv - shared types and constants for the drum lane judge
// Contents: game state enum, default lane geometry, miss limit, streak bonus threshold.
package drum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int DEF_NUM_LANES  = 4;
    localparam int DEF_LANE_DEPTH = 16;
    localparam int DEF_SCORE_W    = 16;
    localparam int DEF_MISS_LIMIT = 10;

    // Streak value (before the current hit) at which a hit earns the bonus.
    localparam int BONUS_STREAK   = 8;

endpackage

// File: rtl/lane_shift.sv
// rtl/lane_shift.sv - one note lane: DEPTH-row shift register with hit-row clear
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   clear_all    : synchronous clear of every row
//   shift        : move every row down by one, row 0 takes load_bit
//   hit_clr      : clear the hit row (row DEPTH-1)
//   load_bit     : note entering row 0 on a shift
//   rows         : lane contents, bit r = row r (registered)
//   hit_bit      : current hit-row content
//   out_bit      : a note leaving the hit row this cycle that was not hit
module lane_shift #(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_all,
    input  logic             shift,
    input  logic             hit_clr,
    input  logic             load_bit,
    output logic [DEPTH-1:0] rows,
    output logic             hit_bit,
    output logic             out_bit
);

    always_ff @(posedge clk) begin
        if (reset || clear_all) begin
            rows <= '0;
        end else if (shift) begin
            // The hit row is discarded by the shift, so a simultaneous
            // hit clear needs no separate action here.
            rows <= {rows[DEPTH-2:0], load_bit};
        end else if (hit_clr) begin
            rows[DEPTH-1] <= 1'b0;
        end
    end

    assign hit_bit = rows[DEPTH-1];
    // A note hit in the same cycle it shifts out is not reported as leaving.
    assign out_bit = shift & rows[DEPTH-1] & ~hit_clr;

endmodule

// File: rtl/drum_lane_judge.sv
// rtl/drum_lane_judge.sv - scrolls note lanes on tick, judges pad hits, keeps score/streak/misses
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   tick       : one-clk scroll pulse
//   start      : starts a new game from IDLE or OVER
//   new_notes  : pattern row loaded into row 0 on each tick
//   pad        : one-clk hit pulses, one per lane
//   lanes      : lane L at [L*LANE_DEPTH +: LANE_DEPTH], bit r = row r
//   hit_flag   : one-clk pulse per successful hit
//   score, streak, miss_count : game counters (saturating)
//   game_over  : high while in OVER
// Build option: DRUM_STREAK_BONUS_EN makes a hit worth 2 once the streak is at least 8.
module drum_lane_judge
    import drum_pkg::*;
#(
    parameter int NUM_LANES  = DEF_NUM_LANES,
    parameter int LANE_DEPTH = DEF_LANE_DEPTH,
    parameter int SCORE_W    = DEF_SCORE_W,
    parameter int MISS_LIMIT = DEF_MISS_LIMIT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tick,
    input  logic                            start,
    input  logic [NUM_LANES-1:0]            new_notes,
    input  logic [NUM_LANES-1:0]            pad,
    output logic [NUM_LANES*LANE_DEPTH-1:0] lanes,
    output logic [NUM_LANES-1:0]            hit_flag,
    output logic [SCORE_W-1:0]              score,
    output logic [7:0]                      streak,
    output logic [7:0]                      miss_count,
    output logic                            game_over
);

    localparam logic [7:0] MISS_LIM8 = 8'(MISS_LIMIT);

    state_t                 state;
    logic                   play_act;
    logic                   clear_lanes;
    logic [NUM_LANES-1:0]   hit_row;
    logic [NUM_LANES-1:0]   out_bits;
    logic [NUM_LANES-1:0]   hits;
    logic [NUM_LANES-1:0]   wrong;

    logic [7:0]             hit_cnt;
    logic [7:0]             miss_cnt;
    logic [1:0]             inc;
    logic [9:0]             score_add;
    logic [SCORE_W:0]       score_sum;
    logic [8:0]             streak_sum;
    logic [8:0]             miss_sum;
    logic [SCORE_W-1:0]     score_next;
    logic [7:0]             streak_next;
    logic [7:0]             miss_next;

    // The cycle that notices the miss limit moves to OVER and does no judging.
    assign play_act    = (state == PLAY) && (miss_count < MISS_LIM8);
    assign clear_lanes = start && (state != PLAY);
    assign hits        = pad &  hit_row & {NUM_LANES{play_act}};
    assign wrong       = pad & ~hit_row & {NUM_LANES{play_act}};

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        lane_shift #(
            .DEPTH (LANE_DEPTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .clear_all (clear_lanes),
            .shift     (tick & play_act),
            .hit_clr   (hits[l]),
            .load_bit  (new_notes[l]),
            .rows      (lanes[l*LANE_DEPTH +: LANE_DEPTH]),
            .hit_bit   (hit_row[l]),
            .out_bit   (out_bits[l])
        );
    end

    always_comb begin
        hit_cnt  = '0;
        miss_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            hit_cnt  = hit_cnt  + 8'(hits[i]);
            miss_cnt = miss_cnt + 8'(out_bits[i]);
        end

`ifdef DRUM_STREAK_BONUS_EN
        // Bonus decision uses the streak as it stood before this cycle's hits.
        inc = (streak >= 8'(BONUS_STREAK)) ? 2'd2 : 2'd1;
`else
        inc = 2'd1;
`endif

        score_add  = 10'(hit_cnt) * 10'(inc);
        score_sum  = {1'b0, score} + (SCORE_W+1)'(score_add);
        score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

        streak_sum = {1'b0, streak} + {1'b0, hit_cnt};
        if ((wrong != '0) || (miss_cnt != 8'd0))
            streak_next = 8'd0;
        else
            streak_next = streak_sum[8] ? 8'hFF : streak_sum[7:0];

        miss_sum  = {1'b0, miss_count} + {1'b0, miss_cnt};
        miss_next = miss_sum[8] ? 8'hFF : miss_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hit_flag   <= '0;
            score      <= '0;
            streak     <= '0;
            miss_count <= '0;
            game_over  <= 1'b0;
        end else begin
            case (state)
                IDLE, OVER: begin
                    hit_flag <= '0;
                    if (start) begin
                        state      <= PLAY;
                        score      <= '0;
                        streak     <= '0;
                        miss_count <= '0;
                        game_over  <= 1'b0;
                    end
                end
                PLAY: begin
                    if (miss_count >= MISS_LIM8) begin
                        state     <= OVER;
                        game_over <= 1'b1;
                        hit_flag  <= '0;
                    end else begin
                        hit_flag   <= hits;
                        score      <= score_next;
                        streak     <= streak_next;
                        miss_count <= miss_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drum_lane_judge.sv
// tb/tb_drum_lane_judge.sv - directed self-checking bench for drum_lane_judge
module tb_drum_lane_judge;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        start;
    logic [3:0]  new_notes;
    logic [3:0]  pad;
    logic [63:0] lanes;
    logic [3:0]  hit_flag;
    logic [15:0] score;
    logic [7:0]  streak;
    logic [7:0]  miss_count;
    logic        game_over;

    int n_tests = 0;
    int n_fail  = 0;

    drum_lane_judge #(
        .NUM_LANES  (4),
        .LANE_DEPTH (16),
        .SCORE_W    (16),
        .MISS_LIMIT (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .new_notes  (new_notes),
        .pad        (pad),
        .lanes      (lanes),
        .hit_flag   (hit_flag),
        .score      (score),
        .streak     (streak),
        .miss_count (miss_count),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are changed 1ns after a rising edge, outputs are read at the same point.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once(input logic [3:0] notes);
        tick = 1'b1; new_notes = notes;
        cycle();
        tick = 1'b0; new_notes = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once(4'b0000);
    endtask

    task automatic press(input logic [3:0] p);
        pad = p;
        cycle();
        pad = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; start = 1'b0; new_notes = '0; pad = '0;
        #2;
        do_reset();
        check("rst_lanes", lanes, 64'h0);
        check("rst_score", 64'(score), 64'd0);
        check("rst_miss", 64'(miss_count), 64'd0);
        check("rst_over", 64'(game_over), 64'd0);
        check("rst_hitflag", 64'(hit_flag), 64'd0);

        // Ticks in IDLE are ignored.
        tick_once(4'b1111);
        check("idle_tick_lanes", lanes, 64'h0);

        pulse_start();

        // Single note reaches the hit row after 15 further ticks, then hit.
        tick_once(4'b0001);
        ticks(15);
        check("note_at_hitrow", lanes, 64'h0000_0000_0000_8000);
        press(4'b0001);
        check("hit1_flag", 64'(hit_flag), 64'h1);
        check("hit1_score", 64'(score), 64'd1);
        check("hit1_streak", 64'(streak), 64'd1);
        check("hit1_lanes", lanes, 64'h0);
        cycle();
        check("hit1_flag_drop", 64'(hit_flag), 64'h0);

        // Same note left alone: the 16th tick after it pushes it out.
        tick_once(4'b0001);
        ticks(15);
        check("miss1_pre", 64'(miss_count), 64'd0);
        ticks(1);
        check("miss1_count", 64'(miss_count), 64'd1);
        check("miss1_streak", 64'(streak), 64'd0);
        check("miss1_score", 64'(score), 64'd1);

        // Three notes in a row on lane 0, all hit -> streak 3, then a wrong hit.
        tick_once(4'b0001); tick_once(4'b0001); tick_once(4'b0001);
        ticks(13);
        press(4'b0001); ticks(1);
        press(4'b0001); ticks(1);
        press(4'b0001);
        check("streak3", 64'(streak), 64'd3);
        check("streak3_score", 64'(score), 64'd4);
        press(4'b0100);
        check("wrong_streak", 64'(streak), 64'd0);
        check("wrong_score", 64'(score), 64'd4);
        check("wrong_miss", 64'(miss_count), 64'd1);
        check("wrong_flag", 64'(hit_flag), 64'h0);

        // Lane 1 note in hit row, pad and tick in the same cycle.
        tick_once(4'b0010);
        ticks(15);
        tick = 1'b1; pad = 4'b0010;
        cycle();
        tick = 1'b0; pad = '0;
        check("same_cyc_flag", 64'(hit_flag), 64'h2);
        check("same_cyc_score", 64'(score), 64'd5);
        check("same_cyc_miss", 64'(miss_count), 64'd1);
        check("same_cyc_streak", 64'(streak), 64'd1);
        check("same_cyc_lanes", lanes, 64'h0);

        // Hit on lane 0 plus wrong hit on lane 1 in one cycle.
        tick_once(4'b0001);
        ticks(15);
        press(4'b0011);
        check("mixed_flag", 64'(hit_flag), 64'h1);
        check("mixed_score", 64'(score), 64'd6);
        check("mixed_streak", 64'(streak), 64'd0);

        // Reset mid-game clears everything.
        tick_once(4'b1010);
        do_reset();
        check("midrst_lanes", lanes, 64'h0);
        check("midrst_score", 64'(score), 64'd0);
        check("midrst_miss", 64'(miss_count), 64'd1 - 64'd1);

        // Miss all four lanes three times with MISS_LIMIT = 10.
        pulse_start();
        tick_once(4'b1111); ticks(16);
        check("miss_round1", 64'(miss_count), 64'd4);
        tick_once(4'b1111); ticks(16);
        check("miss_round2", 64'(miss_count), 64'd8);
        check("miss_round2_over", 64'(game_over), 64'd0);
        tick_once(4'b1111); tick_once(4'b0001); ticks(14);
        ticks(1);
        check("miss_round3", 64'(miss_count), 64'd12);
        check("miss_round3_lanes", lanes, 64'h0000_0000_0000_8000);
        check("over_not_yet", 64'(game_over), 64'd0);
        cycle();
        check("over_set", 64'(game_over), 64'd1);

        // Frozen in OVER: tick and pad ignored.
        tick = 1'b1; new_notes = 4'b1111; pad = 4'b0001;
        cycle();
        tick = 1'b0; new_notes = '0; pad = '0;
        check("over_lanes_frozen", lanes, 64'h0000_0000_0000_8000);
        check("over_score", 64'(score), 64'd0);
        check("over_flag", 64'(hit_flag), 64'h0);
        check("over_miss", 64'(miss_count), 64'd12);

        // Start together with tick: clear wins.
        start = 1'b1; tick = 1'b1; new_notes = 4'b1111;
        cycle();
        start = 1'b0; tick = 1'b0; new_notes = '0;
        check("restart_lanes", lanes, 64'h0);
        check("restart_miss", 64'(miss_count), 64'd0);
        check("restart_over", 64'(game_over), 64'd0);

        // Ten consecutive hits on lane 0.
        for (int i = 0; i < 10; i++) tick_once(4'b0001);
        ticks(6);
        for (int i = 0; i < 10; i++) begin
            press(4'b0001);
            ticks(1);
        end
`ifdef DRUM_STREAK_BONUS_EN
        check("ten_hits_score", 64'(score), 64'd12);
`else
        check("ten_hits_score", 64'(score), 64'd10);
`endif
        check("ten_hits_streak", 64'(streak), 64'd10);
        check("ten_hits_miss", 64'(miss_count), 64'd0);
        check("ten_hits_lanes", lanes, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
